// File: rtl/i2s_rate_switch_ctrl_if.sv
// i2s_rate_switch_ctrl_if
// Control-side bundle between the rate-control register block and the
// I2S rate-switch sequencer.
//   req_valid   : single-cycle rate-change request strobe
//   req_rate    : requested rate (0=48k, 1=96k, 2/3=192k), valid with req_valid
//   req_ack     : one-cycle completion pulse
//   busy        : sequencer is not idle
//   lrclk_fault : sticky LRCLK edge-timeout flag
// master = register side, slave = sequencer.
interface i2s_rate_switch_ctrl_if;
    logic       req_valid;
    logic [1:0] req_rate;
    logic       req_ack;
    logic       busy;
    logic       lrclk_fault;

    modport master (
        output req_valid,
        output req_rate,
        input  req_ack,
        input  busy,
        input  lrclk_fault
    );

    modport slave (
        input  req_valid,
        input  req_rate,
        output req_ack,
        output busy,
        output lrclk_fault
    );
endinterface

// File: rtl/i2s_rate_switch_ctrl.sv
// i2s_rate_switch_ctrl
// Sequences sample-rate changes of the I2S master clock generator so that
// BCLK/LRCLK never change mid-frame: wait for a frame boundary, mute and
// drain, hold the generator in reset while the new rate is applied, let the
// clocks settle, then unmute. Everything runs in the SAICLK domain.
// Ports:
//   SAICLK      : clock, all logic on posedge
//   reset       : asynchronous active-high reset
//   ctrl        : request/ack/busy/fault bundle (slave side)
//   LRCLK       : LRCLK from the generator, asynchronous, 2-flop synchronised
//   s_rate      : rate applied to the generator
//   div_reset_n : active-low reset to the generator
//   mute        : 1 = audio path outputs zeros
module i2s_rate_switch_ctrl #(
    parameter int INIT_RATE     = 0,
    parameter int RESET_CYCLES  = 8,
    parameter int MUTE_FRAMES   = 2,
    parameter int SETTLE_FRAMES = 4,
    parameter int EDGE_TIMEOUT  = 1024
) (
    input  logic                        SAICLK,
    input  logic                        reset,
    i2s_rate_switch_ctrl_if.slave       ctrl,
    input  logic                        LRCLK,
    output logic [1:0]                  s_rate,
    output logic                        div_reset_n,
    output logic                        mute
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        WAIT_EDGE = 3'd1,
        DRAIN     = 3'd2,
        HOLD_RST  = 3'd3,
        SETTLE    = 3'd4,
        UNMUTE    = 3'd5
    } state_t;

    // Rate 3 is an alias of 192k; store and compare it as 2.
    function automatic logic [1:0] norm_rate(input logic [1:0] r);
        norm_rate = (r == 2'd3) ? 2'd2 : r;
    endfunction

    localparam logic [1:0]  INIT_N      = (INIT_RATE >= 2) ? 2'd2 : 2'(INIT_RATE);
    localparam logic [7:0]  RST_LAST    = 8'(RESET_CYCLES - 1);
    localparam logic [3:0]  MUTE_LAST   = 4'(MUTE_FRAMES - 1);
    localparam logic [3:0]  SETTLE_LAST = 4'(SETTLE_FRAMES - 1);
    localparam logic [15:0] TOUT_LAST   = 16'(EDGE_TIMEOUT - 1);

    state_t      state_q, state_d;
    logic [1:0]  s_rate_q, s_rate_d;
    logic [1:0]  target_q, target_d;
    logic        pend_valid_q, pend_valid_d;
    logic [1:0]  pend_rate_q, pend_rate_d;
    logic [3:0]  frame_cnt_q, frame_cnt_d;
    logic [7:0]  cyc_cnt_q, cyc_cnt_d;
    logic [15:0] tout_q, tout_d;
    logic        fault_q, fault_d;
    logic        ack_q, ack_d;
    logic        mute_q, mute_d;
    logic        div_reset_n_q, div_reset_n_d;
    logic        busy_q, busy_d;
    logic        startup_q, startup_d;
    logic        lr_s1_q, lr_s2_q, lr_prev_q;

    logic        frame_edge_s;
    logic        waiting_s;
    logic        timeout_s;
    logic        frame_ev_s;
    logic [1:0]  req_target_s;

    // Two-flop LRCLK synchroniser plus one delayed copy for edge detection
    always_ff @(posedge SAICLK or posedge reset) begin
        if (reset) begin
            lr_s1_q   <= 1'b0;
            lr_s2_q   <= 1'b0;
            lr_prev_q <= 1'b0;
        end else begin
            lr_s1_q   <= LRCLK;
            lr_s2_q   <= lr_s1_q;
            lr_prev_q <= lr_s2_q;
        end
    end

    // Frame-event qualification: a real falling edge or an expired wait
    always_comb begin
        frame_edge_s = ~lr_s2_q & lr_prev_q;
        waiting_s    = (state_q == WAIT_EDGE) || (state_q == DRAIN) || (state_q == SETTLE);
        timeout_s    = waiting_s && (tout_q == TOUT_LAST);
        frame_ev_s   = waiting_s && (frame_edge_s || timeout_s);
        // A fresh strobe wins over an older pending request
        if (ctrl.req_valid) begin
            req_target_s = norm_rate(ctrl.req_rate);
        end else begin
            req_target_s = pend_rate_q;
        end
    end

    // Next-state, counter and output computation
    always_comb begin
        state_d      = state_q;
        s_rate_d     = s_rate_q;
        target_d     = target_q;
        pend_valid_d = pend_valid_q;
        pend_rate_d  = pend_rate_q;
        frame_cnt_d  = frame_cnt_q;
        cyc_cnt_d    = cyc_cnt_q;
        ack_d        = 1'b0;
        startup_d    = startup_q;
        fault_d      = fault_q | timeout_s;

        // One-deep pending slot, last request wins
        if (ctrl.req_valid) begin
            pend_valid_d = 1'b1;
            pend_rate_d  = norm_rate(ctrl.req_rate);
        end else begin
            pend_valid_d = pend_valid_q;
        end

        case (state_q)
            IDLE: begin
                if (ctrl.req_valid || pend_valid_q) begin
                    pend_valid_d = 1'b0;
                    target_d     = req_target_s;
                    if (req_target_s == s_rate_q) begin
                        ack_d = 1'b1;
                    end else begin
                        state_d = WAIT_EDGE;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            WAIT_EDGE: begin
                if (frame_ev_s) begin
                    state_d     = DRAIN;
                    frame_cnt_d = 4'd0;
                end else begin
                    state_d = WAIT_EDGE;
                end
            end
            DRAIN: begin
                if (frame_ev_s) begin
                    if (frame_cnt_q == MUTE_LAST) begin
                        state_d   = HOLD_RST;
                        cyc_cnt_d = 8'd0;
                        // New rate goes out together with the generator reset
                        s_rate_d  = target_q;
                    end else begin
                        frame_cnt_d = frame_cnt_q + 4'd1;
                    end
                end else begin
                    state_d = DRAIN;
                end
            end
            HOLD_RST: begin
                if (cyc_cnt_q == RST_LAST) begin
                    state_d     = SETTLE;
                    frame_cnt_d = 4'd0;
                end else begin
                    cyc_cnt_d = cyc_cnt_q + 8'd1;
                end
            end
            SETTLE: begin
                if (frame_ev_s) begin
                    if (frame_cnt_q == SETTLE_LAST) begin
                        state_d = UNMUTE;
                        // The power-up sequence completes silently
                        ack_d   = ~startup_q;
                    end else begin
                        frame_cnt_d = frame_cnt_q + 4'd1;
                    end
                end else begin
                    state_d = SETTLE;
                end
            end
            UNMUTE: begin
                state_d   = IDLE;
                startup_d = 1'b0;
            end
            default: begin
                state_d   = HOLD_RST;
                cyc_cnt_d = 8'd0;
            end
        endcase

        // Edge-wait timer restarts on every state entry and every frame event
        if (!waiting_s || frame_ev_s || (state_d != state_q)) begin
            tout_d = 16'd0;
        end else begin
            tout_d = tout_q + 16'd1;
        end

        // Outputs registered from the next state so they align with state_q
        mute_d        = (state_d == DRAIN) || (state_d == HOLD_RST) || (state_d == SETTLE);
        div_reset_n_d = (state_d != HOLD_RST);
        busy_d        = (state_d != IDLE);
    end

    // State, counters and registered outputs
    always_ff @(posedge SAICLK or posedge reset) begin
        if (reset) begin
            state_q       <= HOLD_RST;
            s_rate_q      <= INIT_N;
            target_q      <= INIT_N;
            pend_valid_q  <= 1'b0;
            pend_rate_q   <= 2'd0;
            frame_cnt_q   <= 4'd0;
            cyc_cnt_q     <= 8'd0;
            tout_q        <= 16'd0;
            fault_q       <= 1'b0;
            ack_q         <= 1'b0;
            mute_q        <= 1'b1;
            div_reset_n_q <= 1'b0;
            busy_q        <= 1'b1;
            startup_q     <= 1'b1;
        end else begin
            state_q       <= state_d;
            s_rate_q      <= s_rate_d;
            target_q      <= target_d;
            pend_valid_q  <= pend_valid_d;
            pend_rate_q   <= pend_rate_d;
            frame_cnt_q   <= frame_cnt_d;
            cyc_cnt_q     <= cyc_cnt_d;
            tout_q        <= tout_d;
            fault_q       <= fault_d;
            ack_q         <= ack_d;
            mute_q        <= mute_d;
            div_reset_n_q <= div_reset_n_d;
            busy_q        <= busy_d;
            startup_q     <= startup_d;
        end
    end

    assign s_rate           = s_rate_q;
    assign div_reset_n      = div_reset_n_q;
    assign mute             = mute_q;
    assign ctrl.req_ack     = ack_q;
    assign ctrl.busy        = busy_q;
    assign ctrl.lrclk_fault = fault_q;

endmodule
